// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver: 8N1 UART deserialiser plus sensor frame reassembly.
// A frame is a sync byte, PAYLOAD_BYTES payload bytes and an XOR checksum byte.
// Good frames update a 102-bit sensor_iterations word.
//   clk_12MHz          in   system clock, rising edge
//   reset              in   asynchronous, active-high
//   rx                 in   UART line, idle high, asynchronous to clk_12MHz
//   sensor_iterations  out  last good frame payload, payload byte 0 in bits [7:0]
//   frame_valid        out  1-cycle pulse, sensor_iterations updated
//   frame_error        out  1-cycle pulse, frame discarded
//   byte_count         out  payload bytes received in the current frame
module serial_frame_receiver #(
  parameter int unsigned CLKS_PER_BIT  = 12,
  parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
  parameter int unsigned PAYLOAD_BYTES = 13,
  parameter int unsigned TIMEOUT_BITS  = 20
) (
  input  logic         clk_12MHz,
  input  logic         reset,
  input  logic         rx,
  output logic [101:0] sensor_iterations,
  output logic         frame_valid,
  output logic         frame_error,
  output logic [3:0]   byte_count
);

  localparam int unsigned BUF_W    = PAYLOAD_BYTES * 8;
  localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int unsigned TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned TO_W     = $clog2(TO_LIMIT + 1);

  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_M1   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TO_LIMIT);
  localparam logic [3:0]       LAST_IDX = 4'(PAYLOAD_BYTES - 1);

  typedef enum logic [1:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_STOP
  } bit_state_t;

  typedef enum logic [1:0] {
    F_WAIT_SYNC,
    F_PAYLOAD,
    F_CHECK
  } frame_state_t;

  // synchroniser and edge detect
  logic rx_meta_q, rx_s_q, rx_prev_q;

  // bit-level receiver
  bit_state_t       bit_state_q, bit_state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_strobe;
  logic             stop_err;

  // frame-level assembler
  frame_state_t     frame_state_q, frame_state_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [7:0]       chk_q, chk_d;
  logic [3:0]       byte_count_q, byte_count_d;
  logic [TO_W-1:0]  idle_q, idle_d;
  logic [101:0]     sensor_q, sensor_d;
  logic             frame_valid_q, frame_valid_d;
  logic             frame_error_q, frame_error_d;
  logic             timeout;

  always_ff @(posedge clk_12MHz or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // A held-low line after a stop error produces no new falling edge, so the
  // receiver naturally waits for rx_s to return high before the next start.
  always_comb begin
    bit_state_d = bit_state_q;
    bit_cnt_d   = bit_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    byte_strobe = 1'b0;
    stop_err    = 1'b0;
    case (bit_state_q)
      B_IDLE: begin
        if (rx_prev_q && !rx_s_q) begin
          bit_state_d = B_START;
          bit_cnt_d   = '0;
        end
      end
      B_START: begin
        if (bit_cnt_q == HALF_M1) begin
          bit_cnt_d   = '0;
          bit_idx_d   = '0;
          bit_state_d = rx_s_q ? B_IDLE : B_DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      B_DATA: begin
        if (bit_cnt_q == BIT_M1) begin
          bit_cnt_d = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            bit_state_d = B_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      B_STOP: begin
        if (bit_cnt_q == BIT_M1) begin
          bit_cnt_d   = '0;
          bit_state_d = B_IDLE;
          if (rx_s_q) begin
            byte_strobe = 1'b1;
          end else begin
            stop_err = 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      default: bit_state_d = B_IDLE;
    endcase
  end

  always_ff @(posedge clk_12MHz or posedge reset) begin
    if (reset) begin
      bit_state_q <= B_IDLE;
      bit_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
    end else begin
      bit_state_q <= bit_state_d;
      bit_cnt_q   <= bit_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
    end
  end

  assign timeout = (idle_q == TO_MAX);

  // The frame FSM consumes the byte in the same cycle as the stop-bit sample,
  // so frame_valid/frame_error are registered one cycle later.
  always_comb begin
    frame_state_d = frame_state_q;
    buf_d         = buf_q;
    chk_d         = chk_q;
    byte_count_d  = byte_count_q;
    sensor_d      = sensor_q;
    frame_valid_d = 1'b0;
    frame_error_d = 1'b0;
    if (byte_strobe) begin
      idle_d = '0;
    end else if (timeout) begin
      idle_d = idle_q;
    end else begin
      idle_d = idle_q + 1'b1;
    end
    case (frame_state_q)
      F_WAIT_SYNC: begin
        if (byte_strobe && shift_q == SYNC_BYTE) begin
          frame_state_d = F_PAYLOAD;
          buf_d         = '0;
          chk_d         = '0;
          byte_count_d  = '0;
        end
      end
      F_PAYLOAD: begin
        if (byte_strobe) begin
          for (int unsigned i = 0; i < PAYLOAD_BYTES; i++) begin
            if (byte_count_q == 4'(i)) begin
              buf_d[i*8 +: 8] = shift_q;
            end
          end
          chk_d        = chk_q ^ shift_q;
          byte_count_d = byte_count_q + 1'b1;
          if (byte_count_q == LAST_IDX) begin
            frame_state_d = F_CHECK;
          end
        end else if (stop_err || timeout) begin
          frame_error_d = 1'b1;
          frame_state_d = F_WAIT_SYNC;
          byte_count_d  = '0;
        end
      end
      F_CHECK: begin
        if (byte_strobe) begin
          if (shift_q == chk_q && buf_q[BUF_W-1:102] == '0) begin
            sensor_d      = buf_q[101:0];
            frame_valid_d = 1'b1;
          end else begin
            frame_error_d = 1'b1;
          end
          frame_state_d = F_WAIT_SYNC;
          byte_count_d  = '0;
        end else if (stop_err || timeout) begin
          frame_error_d = 1'b1;
          frame_state_d = F_WAIT_SYNC;
          byte_count_d  = '0;
        end
      end
      default: begin
        frame_state_d = F_WAIT_SYNC;
        byte_count_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_12MHz or posedge reset) begin
    if (reset) begin
      frame_state_q <= F_WAIT_SYNC;
      buf_q         <= '0;
      chk_q         <= '0;
      byte_count_q  <= '0;
      idle_q        <= '0;
      sensor_q      <= '0;
      frame_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      frame_state_q <= frame_state_d;
      buf_q         <= buf_d;
      chk_q         <= chk_d;
      byte_count_q  <= byte_count_d;
      idle_q        <= idle_d;
      sensor_q      <= sensor_d;
      frame_valid_q <= frame_valid_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign sensor_iterations = sensor_q;
  assign frame_valid       = frame_valid_q;
  assign frame_error       = frame_error_q;
  assign byte_count        = byte_count_q;

endmodule
